mips_core: RTL and testbench



---
 rtl/mips_core.sv | 243 ++++++++++++++++++++++++
 tb/tb_mips_core.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_core.sv
// -----------------------------------------------------------------------------
// mips_core: single-cycle 32-bit MIPS subset processor.
//
// Every instruction is fetched, decoded, executed and written back in one
// clock. The instruction memory, register file and data memory are internal.
// Only the program counter is visible from outside.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   rst    in   1   asynchronous active-high reset (PC -> RESET_PC, regs -> 0)
//   clr    in   1   synchronous active-high PC clear; suppresses all writes
//   pc_out out  32  current program counter (the PC register itself)
//
// Instance names registers / instructionmem / datamem and their arrays
// (mem, mem_array) are relied upon for hierarchical preloading.
//
// Optional feature macro: MIPS_BNE_EN
//   defined   -> opcode 000101 (bne) branches when rs != rt
//   undefined -> opcode 000101 executes as a NOP
//
// Supported: add sub and or slt addi andi ori lw sw beq j.
// Anything else executes as a NOP (PC + 4, no writes).
// -----------------------------------------------------------------------------

// Register file: 32 x 32, two combinational read ports, one write port.
// $0 reads as zero and ignores writes.
module mips_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr_a,
   input  logic [4:0]  raddr_b,
   output logic [31:0] rdata_a,
   output logic [31:0] rdata_b
);
   logic [31:0] mem [0:31];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) mem[i] <= '0;
      end else if (we && (waddr != 5'd0)) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a = (raddr_a == 5'd0) ? '0 : mem[raddr_a];
   assign rdata_b = (raddr_b == 5'd0) ? '0 : mem[raddr_b];
endmodule

// Instruction memory: combinational word read. The load port exists only
// so the array has a writer in hardware; the core ties it off.
module mips_imem #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [31:0]   load_data,
   input  logic [AW-1:0] addr,
   output logic [31:0]   rdata
);
   logic [31:0] mem_array [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (load_en) mem_array[load_addr] <= load_data;
   end

   assign rdata = mem_array[addr];
endmodule

// Data memory: combinational word read, synchronous word write.
module mips_dmem #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   logic [31:0] mem_array [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) mem_array[addr] <= wdata;
   end

   assign rdata = mem_array[addr];
endmodule

module mips_core #(
   parameter int          IMEM_DEPTH = 256,
   parameter int          DMEM_DEPTH = 256,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   output logic [31:0] pc_out
);
   localparam int IAW = $clog2(IMEM_DEPTH);
   localparam int DAW = $clog2(DMEM_DEPTH);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;
   logic [31:0] rs_val, rt_val;
   logic [31:0] sext_imm, zext_imm;
   logic [31:0] pc_plus4, branch_target, jump_target;
   logic [31:0] alu_res, rf_wdata, dm_rdata;
   logic [4:0]  rf_waddr;
   logic        rf_we, dm_we, mem_to_reg;

   mips_imem #(.DEPTH(IMEM_DEPTH)) instructionmem (
      .clk       (clk),
      .load_en   (1'b0),
      .load_addr ('0),
      .load_data ('0),
      .addr      (pc_q[IAW+1:2]),
      .rdata     (instr)
   );

   mips_regfile registers (
      .clk     (clk),
      .rst     (rst),
      .we      (rf_we),
      .waddr   (rf_waddr),
      .wdata   (rf_wdata),
      .raddr_a (rs),
      .raddr_b (rt),
      .rdata_a (rs_val),
      .rdata_b (rt_val)
   );

   mips_dmem #(.DEPTH(DMEM_DEPTH)) datamem (
      .clk   (clk),
      .we    (dm_we),
      .addr  (alu_res[DAW+1:2]),
      .wdata (rt_val),
      .rdata (dm_rdata)
   );

   assign opcode = instr[31:26];
   assign rs     = instr[25:21];
   assign rt     = instr[20:16];
   assign rd     = instr[15:11];
   assign funct  = instr[5:0];
   assign imm    = instr[15:0];

   assign sext_imm      = {{16{imm[15]}}, imm};
   assign zext_imm      = {16'h0000, imm};
   assign pc_plus4      = pc_q + 32'd4;
   assign branch_target = pc_plus4 + {sext_imm[29:0], 2'b00};
   // The jump target field already carries the shamt/funct bits of the word.
   assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};

   assign rf_wdata = mem_to_reg ? dm_rdata : alu_res;

   always_comb begin
      pc_d       = pc_plus4;
      rf_we      = 1'b0;
      rf_waddr   = rt;
      alu_res    = '0;
      dm_we      = 1'b0;
      mem_to_reg = 1'b0;

      case (opcode)
         OP_RTYPE: begin
            rf_waddr = rd;
            case (funct)
               FN_ADD: begin alu_res = rs_val + rt_val; rf_we = 1'b1; end
               FN_SUB: begin alu_res = rs_val - rt_val; rf_we = 1'b1; end
               FN_AND: begin alu_res = rs_val & rt_val; rf_we = 1'b1; end
               FN_OR:  begin alu_res = rs_val | rt_val; rf_we = 1'b1; end
               FN_SLT: begin
                  alu_res = {31'b0, $signed(rs_val) < $signed(rt_val)};
                  rf_we   = 1'b1;
               end
               default: ;
            endcase
         end
         OP_ADDI: begin alu_res = rs_val + sext_imm; rf_we = 1'b1; end
         OP_ANDI: begin alu_res = rs_val & zext_imm; rf_we = 1'b1; end
         OP_ORI:  begin alu_res = rs_val | zext_imm; rf_we = 1'b1; end
         OP_LW: begin
            alu_res    = rs_val + sext_imm;
            mem_to_reg = 1'b1;
            rf_we      = 1'b1;
         end
         OP_SW: begin
            alu_res = rs_val + sext_imm;
            dm_we   = 1'b1;
         end
         OP_BEQ: begin
            if (rs_val == rt_val) pc_d = branch_target;
         end
`ifdef MIPS_BNE_EN
         OP_BNE: begin
            if (rs_val != rt_val) pc_d = branch_target;
         end
`else
         OP_BNE: ;
`endif
         OP_J: pc_d = jump_target;
         default: ;
      endcase

      // Clear wins over whatever the instruction wanted to do this cycle.
      if (clr) begin
         pc_d  = RESET_PC;
         rf_we = 1'b0;
         dm_we = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pc_q <= RESET_PC;
      else     pc_q <= pc_d;
   end

   assign pc_out = pc_q;
endmodule

// File: tb/tb_mips_core.sv
// -----------------------------------------------------------------------------
// tb_mips_core: self-checking bench for mips_core.
// Programs are preloaded through the hierarchical memory names. Expected
// PC values (and register values where relevant) are pushed to queues as
// each step is set up and popped/compared one ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_mips_core;
   logic        clk;
   logic        rst;
   logic        clr;
   logic [31:0] pc_out;

   int vectors;
   int miscompares;

   logic [31:0] exp_q[$];    // expected pc_out after each edge
   logic [31:0] exp_rq[$];   // expected register value after each edge
   logic [4:0]  exp_iq[$];   // register index for exp_rq

   mips_core dut (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .pc_out (pc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
      return {6'b000000, rs, rt, rd, 5'b00000, fn};
   endfunction

   function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // Hold reset, blank the instruction memory with NOPs, clear the queues.
   task automatic begin_program();
      rst = 1'b1;
      clr = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 256; i++) dut.instructionmem.mem_array[i] = 32'h0;
      exp_q.delete();
      exp_rq.delete();
      exp_iq.delete();
   endtask

   task automatic test_reset();
      logic [31:0] exp_pc;
      logic [31:0] got;
      begin_program();
      dut.registers.mem[7] = 32'h55;
      @(negedge clk);
      vectors++;
      if (pc_out !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_pc: got %h expected %h", pc_out, 32'h0);
      end
      vectors++;
      got = dut.registers.mem[7];
      if (got !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_regs: got %h expected %h", got, 32'h0);
      end
      rst = 1'b0;
      exp_pc = 32'h0;
      for (int i = 0; i < 3; i++) begin
         exp_pc += 32'd4;
         exp_q.push_back(exp_pc);
         @(posedge clk);
         #1;
         vectors++;
         if (pc_out !== exp_q[0]) begin
            miscompares++;
            $display("FAIL reset_run_pc: got %h expected %h", pc_out, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
      // Mid-run reset pulse of 11 ns, starting between edges.
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      vectors++;
      if (pc_out !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_async_pc: got %h expected %h", pc_out, 32'h0);
      end
      #10 rst = 1'b0;
      exp_pc = 32'h0;
      for (int i = 0; i < 3; i++) begin
         exp_pc += 32'd4;
         exp_q.push_back(exp_pc);
         @(posedge clk);
         #1;
         vectors++;
         if (pc_out !== exp_q[0]) begin
            miscompares++;
            $display("FAIL reset_rerun_pc: got %h expected %h", pc_out, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_addi_zero();
      logic [31:0] got;
      begin_program();
      dut.instructionmem.mem_array[0] = 32'h20400003;
      rst = 1'b0;
      for (int i = 0; i < 32; i++) dut.registers.mem[i] = i;
      exp_q.push_back(32'd4);
      @(posedge clk);
      #1;
      vectors++;
      if (pc_out !== exp_q[0]) begin
         miscompares++;
         $display("FAIL addi_zero_pc: got %h expected %h", pc_out, exp_q[0]);
      end
      void'(exp_q.pop_front());
      vectors++;
      got = dut.registers.mem[0];
      if (got !== 32'h0) begin
         miscompares++;
         $display("FAIL addi_zero_r0: got %h expected %h", got, 32'h0);
      end
   endtask

   task automatic test_addi_add();
      logic [31:0] got;
      begin_program();
      dut.instructionmem.mem_array[0] = 32'h20430003;
      dut.instructionmem.mem_array[1] = 32'h00622020;
      rst = 1'b0;
      for (int i = 0; i < 32; i++) dut.registers.mem[i] = i;
      exp_q.push_back(32'd4); exp_iq.push_back(5'd3); exp_rq.push_back(32'd5);
      exp_q.push_back(32'd8); exp_iq.push_back(5'd4); exp_rq.push_back(32'd7);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (pc_out !== exp_q[0]) begin
            miscompares++;
            $display("FAIL addi_add_pc: got %h expected %h", pc_out, exp_q[0]);
         end
         vectors++;
         got = dut.registers.mem[exp_iq[0]];
         if (got !== exp_rq[0]) begin
            miscompares++;
            $display("FAIL addi_add_reg%0d: got %h expected %h", exp_iq[0], got, exp_rq[0]);
         end
         void'(exp_q.pop_front());
         void'(exp_iq.pop_front());
         void'(exp_rq.pop_front());
      end
   endtask

   task automatic test_alu();
      logic [31:0] got;
      logic [4:0]  ridx [0:9];
      logic [31:0] rexp [0:9];
      begin_program();
      dut.instructionmem.mem_array[0]  = r_type(5'd9,  5'd8,  5'd11, 6'b100010);
      dut.instructionmem.mem_array[1]  = r_type(5'd10, 5'd9,  5'd12, 6'b100100);
      dut.instructionmem.mem_array[2]  = r_type(5'd8,  5'd9,  5'd13, 6'b100101);
      dut.instructionmem.mem_array[3]  = r_type(5'd8,  5'd9,  5'd14, 6'b101010);
      dut.instructionmem.mem_array[4]  = r_type(5'd9,  5'd8,  5'd15, 6'b101010);
      dut.instructionmem.mem_array[5]  = i_type(6'b001100, 5'd10, 5'd16, 16'hF0F0);
      dut.instructionmem.mem_array[6]  = i_type(6'b001101, 5'd8,  5'd17, 16'h8001);
      dut.instructionmem.mem_array[7]  = i_type(6'b001000, 5'd9,  5'd18, 16'hFFFA);
      dut.instructionmem.mem_array[8]  = r_type(5'd8,  5'd8,  5'd19, 6'b100000);
      dut.instructionmem.mem_array[9]  = r_type(5'd8,  5'd9,  5'd20, 6'b100111);
      dut.instructionmem.mem_array[10] = i_type(6'b000101, 5'd9, 5'd8, 16'h0003);
      rst = 1'b0;
      dut.registers.mem[8]  = 32'h8000_0000;
      dut.registers.mem[9]  = 32'h0000_0005;
      dut.registers.mem[10] = 32'hFFFF_FFFF;
      for (int i = 11; i < 20; i++) dut.registers.mem[i] = 32'hDEAD_BEEF;
      dut.registers.mem[20] = 32'h0000_1234;
      ridx[0] = 5'd11; rexp[0] = 32'h8000_0005;
      ridx[1] = 5'd12; rexp[1] = 32'h0000_0005;
      ridx[2] = 5'd13; rexp[2] = 32'h8000_0005;
      ridx[3] = 5'd14; rexp[3] = 32'h0000_0001;
      ridx[4] = 5'd15; rexp[4] = 32'h0000_0000;
      ridx[5] = 5'd16; rexp[5] = 32'h0000_F0F0;
      ridx[6] = 5'd17; rexp[6] = 32'h8000_8001;
      ridx[7] = 5'd18; rexp[7] = 32'hFFFF_FFFF;
      ridx[8] = 5'd19; rexp[8] = 32'h0000_0000;
      ridx[9] = 5'd20; rexp[9] = 32'h0000_1234;
      for (int i = 1; i <= 10; i++) exp_q.push_back(32'(i * 4));
`ifdef MIPS_BNE_EN
      exp_q.push_back(32'd56);
`else
      exp_q.push_back(32'd44);
`endif
      for (int i = 0; i < 11; i++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (pc_out !== exp_q[0]) begin
            miscompares++;
            $display("FAIL alu_pc step %0d: got %h expected %h", i, pc_out, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
      for (int i = 0; i < 10; i++) begin
         vectors++;
         got = dut.registers.mem[ridx[i]];
         if (got !== rexp[i]) begin
            miscompares++;
            $display("FAIL alu_reg%0d: got %h expected %h", ridx[i], got, rexp[i]);
         end
      end
      vectors++;
      got = dut.registers.mem[8];
      if (got !== 32'h8000_0000) begin
         miscompares++;
         $display("FAIL bne_no_write: got %h expected %h", got, 32'h8000_0000);
      end
   endtask

   task automatic test_load_store();
      logic [31:0] got;
      begin_program();
      dut.datamem.mem_array[5]   = 32'h0000_00AB;
      dut.datamem.mem_array[255] = 32'h0000_0011;
      dut.datamem.mem_array[0]   = 32'h0;
      dut.datamem.mem_array[1]   = 32'h0;
      dut.instructionmem.mem_array[0] = 32'h8C060014;                            // lw $6,20($0)
      dut.instructionmem.mem_array[1] = i_type(6'b100011, 5'd0, 5'd7, 16'hFFFC); // lw $7,-4($0)
      dut.instructionmem.mem_array[2] = 32'hAC060000;                            // sw $6,0($0)
      dut.instructionmem.mem_array[3] = i_type(6'b101011, 5'd0, 5'd7, 16'h0404); // sw $7,0x404($0)
      rst = 1'b0;
      for (int i = 1; i <= 4; i++) exp_q.push_back(32'(i * 4));
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (pc_out !== exp_q[0]) begin
            miscompares++;
            $display("FAIL ldst_pc step %0d: got %h expected %h", i, pc_out, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
      vectors++;
      got = dut.registers.mem[6];
      if (got !== 32'h0000_00AB) begin
         miscompares++;
         $display("FAIL lw_r6: got %h expected %h", got, 32'h0000_00AB);
      end
      vectors++;
      got = dut.registers.mem[7];
      if (got !== 32'h0000_0011) begin
         miscompares++;
         $display("FAIL lw_neg_wrap_r7: got %h expected %h", got, 32'h0000_0011);
      end
      vectors++;
      got = dut.datamem.mem_array[0];
      if (got !== 32'h0000_00AB) begin
         miscompares++;
         $display("FAIL sw_word0: got %h expected %h", got, 32'h0000_00AB);
      end
      vectors++;
      got = dut.datamem.mem_array[1];
      if (got !== 32'h0000_0011) begin
         miscompares++;
         $display("FAIL sw_wrap_word1: got %h expected %h", got, 32'h0000_0011);
      end
   endtask

   task automatic test_branch_loop();
      begin_program();
      dut.instructionmem.mem_array[0] = 32'h1021FFFF;
      rst = 1'b0;
      dut.registers.mem[1] = 32'd1;
      for (int i = 0; i < 3; i++) exp_q.push_back(32'h0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (pc_out !== exp_q[0]) begin
            miscompares++;
            $display("FAIL beq_self_pc step %0d: got %h expected %h", i, pc_out, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_jump_clr();
      logic [31:0] got;
      begin_program();
      dut.instructionmem.mem_array[0]  = i_type(6'b000100, 5'd1, 5'd2, 16'h0002); // not taken
      dut.instructionmem.mem_array[1]  = i_type(6'b000100, 5'd0, 5'd0, 16'h0002); // taken -> 16
      dut.instructionmem.mem_array[4]  = 32'h08000010;                            // j 0x10
      dut.instructionmem.mem_array[16] = 32'h20050077;                            // addi $5,$0,0x77
      rst = 1'b0;
      for (int i = 0; i < 32; i++) dut.registers.mem[i] = i;
      dut.registers.mem[5] = 32'h99;
      exp_q.push_back(32'h04);
      exp_q.push_back(32'h10);
      exp_q.push_back(32'h40);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (pc_out !== exp_q[0]) begin
            miscompares++;
            $display("FAIL flow_pc step %0d: got %h expected %h", i, pc_out, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
      @(negedge clk);
      clr = 1'b1;
      exp_q.push_back(32'h0);
      @(posedge clk);
      #1;
      vectors++;
      if (pc_out !== exp_q[0]) begin
         miscompares++;
         $display("FAIL clr_pc: got %h expected %h", pc_out, exp_q[0]);
      end
      void'(exp_q.pop_front());
      vectors++;
      got = dut.registers.mem[5];
      if (got !== 32'h99) begin
         miscompares++;
         $display("FAIL clr_no_write: got %h expected %h", got, 32'h99);
      end
      @(negedge clk);
      clr = 1'b0;
      exp_q.push_back(32'h04);
      @(posedge clk);
      #1;
      vectors++;
      if (pc_out !== exp_q[0]) begin
         miscompares++;
         $display("FAIL after_clr_pc: got %h expected %h", pc_out, exp_q[0]);
      end
      void'(exp_q.pop_front());
   endtask

   // Random addi chain placed at the top of instruction memory, reached by a
   // jump; the PC runs past the last word and wraps back to word 0.
   task automatic test_back_to_back();
      logic [31:0] model [0:7];
      logic [31:0] prog [0:7];
      logic [31:0] exp_pc;
      logic [31:0] ins;
      logic [31:0] got;
      logic [4:0]  mrs, mrt;
      int          word;
      begin_program();
      for (int i = 0; i < 8; i++) begin
         prog[i] = i_type(6'b001000, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          16'($urandom_range(0, 65535)));
         dut.instructionmem.mem_array[248 + i] = prog[i];
      end
      dut.instructionmem.mem_array[0] = {6'b000010, 26'd248};
      rst = 1'b0;
      model[0] = 32'h0;
      dut.registers.mem[0] = 32'h0;
      for (int i = 1; i < 8; i++) begin
         model[i] = $urandom;
         dut.registers.mem[i] = model[i];
      end
      exp_pc = 32'h0;
      for (int s = 0; s < 18; s++) begin
         word = int'(exp_pc[9:2]);
         if (word == 0) begin
            exp_pc = {exp_pc[31:28] + ((exp_pc[27:0] + 28'd4 == 28'd0) ? 4'd1 : 4'd0),
                      26'd248, 2'b00};
            exp_iq.push_back(5'd0);
            exp_rq.push_back(32'h0);
         end else begin
            ins = prog[word - 248];
            mrs = ins[25:21];
            mrt = ins[20:16];
            if (mrt != 5'd0) model[mrt] = model[mrs] + {{16{ins[15]}}, ins[15:0]};
            exp_pc = exp_pc + 32'd4;
            exp_iq.push_back(mrt);
            exp_rq.push_back(model[mrt]);
         end
         exp_q.push_back(exp_pc);
      end
      for (int s = 0; s < 18; s++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (pc_out !== exp_q[0]) begin
            miscompares++;
            $display("FAIL b2b_pc step %0d: got %h expected %h", s, pc_out, exp_q[0]);
         end
         vectors++;
         got = dut.registers.mem[exp_iq[0]];
         if (got !== exp_rq[0]) begin
            miscompares++;
            $display("FAIL b2b_reg%0d step %0d: got %h expected %h", exp_iq[0], s, got, exp_rq[0]);
         end
         void'(exp_q.pop_front());
         void'(exp_iq.pop_front());
         void'(exp_rq.pop_front());
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      clr         = 1'b0;
      test_reset();
      test_addi_zero();
      test_addi_add();
      test_alu();
      test_load_store();
      test_branch_loop();
      test_jump_clr();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
